// File: rtl/fp8_mac_pkg.sv
// Shared types for the FP8 dot-product sequencer: operand width, FSM states, FIFO entry.
// Pure declarations; no logic, latency or flow control of its own.
package fp8_mac_pkg;

  localparam int FP8_W = 8;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_FLUSH = 3'd4,
    S_OUT   = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic             last;
    logic [FP8_W-1:0] a;
    logic [FP8_W-1:0] b;
  } fifo_entry_t;

endpackage

// File: rtl/fp8_pair_fifo.sv
// Synchronous operand-pair FIFO with show-ahead head; a write is visible on rd_data the next cycle.
// Writes while full and reads while empty are dropped; simultaneous push and pop both take effect.
module fp8_pair_fifo
  import fp8_mac_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  fifo_entry_t wr_data,
  input  logic        rd_en,
  output fifo_entry_t rd_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t    mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_wr;
  logic           do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_rd) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fp8_dot_sequencer.sv
// Feeds FP8 operand pairs to the MAC PE one at a time and returns the accumulated result per vector.
// mac_start two cycles after a push into an idle empty FIFO; input stalls only when full; result held until out_ready.
module fp8_dot_sequencer
  import fp8_mac_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP8_W-1:0] in_a,
  input  logic [FP8_W-1:0] in_b,
  input  logic             in_last,
  output logic             mac_start,
  output logic [FP8_W-1:0] mac_a,
  output logic [FP8_W-1:0] mac_b,
  input  logic             mac_done,
  input  logic [FP8_W-1:0] mac_acc,
  output logic             mac_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP8_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  seq_state_t  state;
  seq_state_t  state_nxt;
  fifo_entry_t push_entry;
  fifo_entry_t head;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        load_op;
  logic        last_q;
  logic [TW-1:0] tcnt;
  logic        timeout_hit;

  assign in_ready    = !full && !rst;
  assign push        = in_valid && in_ready;
  assign push_entry  = '{last: in_last, a: in_a, b: in_b};
  assign timeout_hit = (tcnt == TW'(TIMEOUT - 1));

  fp8_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (push_entry),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_op   = 1'b0;
    case (state)
      S_CLEAR: state_nxt = S_IDLE;
      S_IDLE: begin
        if (!empty) begin
          state_nxt = S_ISSUE;
          load_op   = 1'b1;
        end
      end
      S_ISSUE: begin
        pop       = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A done coinciding with the timeout counts as a normal completion.
        if (mac_done) begin
          if (last_q) begin
            state_nxt = S_OUT;
          end else if (!empty) begin
            state_nxt = S_ISSUE;
            load_op   = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end else if (timeout_hit) begin
          state_nxt = last_q ? S_OUT : S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.last) state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) state_nxt = S_CLEAR;
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  // Operands are captured on entry to ISSUE so they are already valid alongside mac_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_start <= 1'b0;
      mac_clr   <= 1'b1;
      out_valid <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      last_q    <= 1'b0;
      tcnt      <= '0;
      out_data  <= '0;
      out_count <= '0;
      out_err   <= 1'b0;
    end else begin
      mac_start <= (state_nxt == S_ISSUE);
      mac_clr   <= (state_nxt == S_CLEAR);
      out_valid <= (state_nxt == S_OUT);
      if (load_op) begin
        mac_a  <= head.a;
        mac_b  <= head.b;
        last_q <= head.last;
      end
      if (state == S_ISSUE)     tcnt <= '0;
      else if (state == S_WAIT) tcnt <= tcnt + TW'(1);
      if (state == S_CLEAR) begin
        out_data  <= '0;
        out_count <= '0;
        out_err   <= 1'b0;
      end else if (state == S_WAIT) begin
        if (mac_done) begin
          out_data <= mac_acc;
          if (out_count != '1) out_count <= out_count + CNT_W'(1);
        end else if (timeout_hit) begin
          out_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp8_dot_sequencer.sv
// Directed and randomized bench for fp8_dot_sequencer with a 3-cycle behavioural PE and a vector-level scoreboard.
module tb_fp8_dot_sequencer;

  localparam int TO = 16;

  typedef struct packed {
    logic       last;
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] c;
  } res_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_last;
  logic       mac_start;
  logic [7:0] mac_a;
  logic [7:0] mac_b;
  logic       mac_done = 1'b0;
  logic [7:0] mac_acc  = 8'h00;
  logic       mac_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] out_count;
  logic       out_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_start = 0;
  int pe_cd = 0;
  int vec_cnt = 0;
  int final_done_cyc = 0;
  int b2b_cyc = 0;
  int last_start_cyc = 0;
  int fixed_acc = -1;
  bit pe_en = 1'b1;
  bit chk_b2b = 1'b0;
  bit cur_vld = 1'b0;
  bit cur_last = 1'b0;
  bit b2b_pend = 1'b0;
  bit saw_full = 1'b0;
  pair_t p;

  pair_t exp_pairs[$];
  res_t  exp_out[$];

  fp8_dot_sequencer #(
    .DEPTH   (4),
    .CNT_W   (8),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .mac_start (mac_start),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_done  (mac_done),
    .mac_acc   (mac_acc),
    .mac_clr   (mac_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // PE model (done 3 cycles after start) plus the vector scoreboard: the result of a
  // vector is the accumulator returned for its last pair and the number of pairs done.
  always @(negedge clk) begin
    if (rst) begin
      exp_pairs.delete();
      cur_vld  = 1'b0;
      vec_cnt  = 0;
      b2b_pend = 1'b0;
    end
    mac_done = 1'b0;
    if (pe_cd > 0) begin
      pe_cd--;
      if (pe_cd == 0) begin
        mac_done = 1'b1;
        mac_acc  = (fixed_acc >= 0) ? 8'(fixed_acc) : 8'($urandom);
        if (cur_vld) begin
          vec_cnt++;
          cur_vld = 1'b0;
          if (cur_last) begin
            exp_out.push_back('{d: mac_acc, c: 8'(vec_cnt)});
            vec_cnt        = 0;
            final_done_cyc = cyc;
            b2b_pend       = 1'b0;
          end else begin
            b2b_pend = 1'b1;
            b2b_cyc  = cyc;
          end
        end
      end
    end
    if (mac_start) begin
      n_start++;
      last_start_cyc = cyc;
      check("start_expected", exp_pairs.size() > 0, 1);
      if (exp_pairs.size() > 0) begin
        p = exp_pairs.pop_front();
        check("mac_a", mac_a, p.a);
        check("mac_b", mac_b, p.b);
        cur_last = p.last;
      end
      cur_vld = 1'b1;
      if (chk_b2b && b2b_pend) check("b2b_gap", cyc, b2b_cyc + 1);
      b2b_pend = 1'b0;
      if (pe_en) pe_cd = 3;
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!in_ready && t < 200) begin
      saw_full = 1'b1;
      @(negedge clk);
      t++;
    end
    check("push_accepted", in_ready, 1);
    if (in_ready) exp_pairs.push_back('{last: last, a: a, b: b});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int hold, input bit lat,
                               input bit use_sb, input bit exp_err);
    int   t = 0;
    res_t e;
    while (!out_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_valid"}, out_valid, 1);
    if (!out_valid) return;
    if (lat) check({tag, "_latency"}, cyc, final_done_cyc + 1);
    e = '0;
    if (use_sb) begin
      check({tag, "_sb_nonempty"}, exp_out.size() > 0, 1);
      if (exp_out.size() > 0) e = exp_out.pop_front();
    end
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold"}, out_valid, 1);
      @(negedge clk);
    end
    check({tag, "_data"}, out_data, e.d);
    check({tag, "_count"}, out_count, e.c);
    check({tag, "_err"}, out_err, exp_err);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_clr_pulse"}, mac_clr, 1);
    check({tag, "_valid_drop"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_clr_end"}, mac_clr, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    int   n0;
    int   t;
    int   d;
    int   lens[8];
    res_t e;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mac_clr", mac_clr, 1);
    check("rst_mac_start", mac_start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_err", out_err, 0);
    check("rst_mac_ab", {mac_a, mac_b}, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("rel_mac_clr", mac_clr, 1);
    check("rel_in_ready", in_ready, 1);
    @(negedge clk);
    check("rel_mac_clr_end", mac_clr, 0);
    repeat (2) @(negedge clk);

    // Single pair: 1.0 * 2.0
    fixed_acc = 8'h40;
    n0 = n_start;
    push(8'h38, 8'h40, 1'b1);
    check("single_start_lat0", mac_start, 0);
    @(negedge clk);
    check("single_start_lat1", mac_start, 1);
    expect_result("single", 2, 1'b1, 1'b1, 1'b0);
    check("single_starts", n_start - n0, 1);
    fixed_acc = -1;

    // Back-to-back 6-pair vector through a 4-deep FIFO
    chk_b2b  = 1'b1;
    saw_full = 1'b0;
    n0 = n_start;
    for (int i = 0; i < 6; i++) push(8'($urandom), 8'($urandom), i == 5);
    check("b2b_saw_full", saw_full, 1);
    expect_result("b2b", 0, 1'b1, 1'b1, 1'b0);
    check("b2b_starts", n_start - n0, 6);
    chk_b2b = 1'b0;

    // Result backpressure while the next vector fills the FIFO
    push(8'h38, 8'h38, 1'b1);
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    check("bp_first_valid", out_valid, 1);
    e = (exp_out.size() > 0) ? exp_out[0] : '0;
    n0 = n_start;
    for (int i = 0; i < 4; i++) push(8'($urandom), 8'($urandom), i == 3);
    check("bp_in_ready_full", in_ready, 0);
    for (int i = 0; i < 6; i++) begin
      check("bp_stable", {out_valid, out_err, out_count, out_data}, {1'b1, 1'b0, e.c, e.d});
      check("bp_no_start", n_start, n0);
      @(negedge clk);
    end
    expect_result("bp_v1", 0, 1'b0, 1'b1, 1'b0);
    check("bp_no_start_in_clear", n_start, n0);
    expect_result("bp_v2", 0, 1'b1, 1'b1, 1'b0);
    check("bp_v2_starts", n_start - n0, 4);

    // Timeout: PE never completes; remainder of the vector is flushed
    pe_en = 1'b0;
    n0 = n_start;
    push(8'h01, 8'h02, 1'b0);
    push(8'h03, 8'h04, 1'b0);
    push(8'h05, 8'h06, 1'b1);
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    check("to_valid", out_valid, 1);
    d = cyc - last_start_cyc;
    check("to_wait_len", (d >= TO + 1) && (d <= 40), 1);
    check("to_starts", n_start - n0, 1);
    check("to_discarded", exp_pairs.size(), 2);
    expect_result("timeout", 1, 1'b0, 1'b0, 1'b1);
    check("to_no_more_starts", n_start - n0, 1);
    exp_pairs.delete();
    pe_en = 1'b1;

    // Randomized vectors with random result backpressure
    for (int v = 0; v < 8; v++) lens[v] = $urandom_range(1, 6);
    fork
      begin
        for (int v = 0; v < 8; v++)
          for (int i = 0; i < lens[v]; i++)
            push(8'($urandom), 8'($urandom), i == lens[v] - 1);
      end
      begin
        for (int v = 0; v < 8; v++) expect_result("rand", $urandom_range(0, 3), 1'b1, 1'b1, 1'b0);
      end
    join

    // Reset during WAIT; the PE's done lands after release and must be ignored
    n0 = n_start;
    push(8'h11, 8'h22, 1'b1);
    t = 0;
    while (!mac_start && t < 50) begin @(negedge clk); t++; end
    check("rw_start", mac_start, 1);
    push(8'h33, 8'h44, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("rw_no_valid", out_valid, 0);
      check("rw_no_reissue", n_start - n0, 1);
    end
    check("rw_in_ready", in_ready, 1);
    check("rw_sb_empty", exp_out.size(), 0);
    check("end_pairs_empty", exp_pairs.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp8_dot_sequencer.md
# fp8_dot_sequencer

Upstream feeder for the FP8 multiply-accumulate PE. It buffers incoming FP8 operand pairs tagged with an end-of-vector flag, issues one MAC operation per pair using a start/done handshake, and returns the accumulated FP8 dot product with a pair count when the vector ends. It clears the PE accumulator between vectors and recovers from a PE that never completes.

## Interface
- `DEPTH`, 4: operand FIFO entries (power of two, ≥2)
- `CNT_W`, 8: width of the pair counter
- `TIMEOUT`, 32: maximum cycles in WAIT before abort (≥4)

- `clk`, in, 1: single clock, rising edge
- `rst`, in, 1: synchronous, active-high reset
- `in_valid` / `in_ready`, in / out, 1 / 1: operand push handshake
- `in_a`, `in_b`, in, 8 each: FP8 operands
- `in_last`, in, 1: pair is the final element of its vector
- `mac_start`, out, 1: one-cycle start pulse to the PE
- `mac_a`, `mac_b`, out, 8 each: operands to the PE, held stable from ISSUE through WAIT
- `mac_done`, in, 1: PE completion pulse
- `mac_acc`, in, 8: PE accumulator value, valid in the `mac_done` cycle
- `mac_clr`, out, 1: accumulator clear request; integration gates the PE reset with it
- `out_valid` / `out_ready`, out / in, 1 / 1: result handshake
- `out_data`, out, 8: FP8 dot-product result
- `out_count`, out, `CNT_W`: pairs accumulated (saturating)
- `out_err`, out, 1: result aborted by timeout

## Operation
- **FIFO**
  - Each entry is {last, a, b}.
  - Push on `in_valid & in_ready`; `in_ready = !full & !rst`.
  - Pop only in ISSUE, or in FLUSH when not empty. A push and a pop in the same cycle are both performed.
- **FSM states:** CLEAR, IDLE, ISSUE, WAIT, FLUSH, OUT.
  - **CLEAR:** `mac_clr`=1 for one cycle. Counter, error flag and result register are zeroed. Next state is IDLE.
  - **IDLE:** go to ISSUE when the FIFO is not empty.
  - **ISSUE:** `mac_start`=1; register the head entry into `mac_a`/`mac_b` and a `last_q` flag; pop. Next state is WAIT. The timeout counter is zeroed.
  - **WAIT:** the timeout counter increments each cycle.
    - On `mac_done`: capture `mac_acc` into the result register and increment the count (saturating at all-ones). Then:
      - if `last_q`, go to OUT;
      - else if the FIFO is not empty, go to ISSUE;
      - else go to IDLE.
    - If the counter reaches `TIMEOUT` with no done: set `out_err`. Go to OUT if `last_q`, else to FLUSH. The count is not incremented.
  - **FLUSH:** pop and discard entries until one with last=1 is popped, then go to OUT. If the FIFO is empty, wait there.
  - **OUT:** `out_valid`=1, with `out_data`/`out_count`/`out_err` driven from registers and held stable. On `out_ready`, go to CLEAR.
- **Ignored inputs:** `mac_done` is ignored outside WAIT. A done that arrives in the same cycle as the timeout wins (normal completion).
- **Reset values:** state CLEAR, `mac_clr`=1, FIFO empty, and every other output 0.

## Timing
- All outputs except `in_ready` are registered.
- From a push into an empty FIFO while IDLE, `mac_start` rises in the second cycle after the handshake cycle.
- On `mac_done` with `last_q`=0 and the FIFO non-empty, the next `mac_start` follows in the very next cycle.
- `out_valid` rises the cycle after the final `mac_done`.
- `mac_clr` is high for exactly one cycle after each accepted result, plus throughout reset and the first cycle after reset.
- Inputs may be pushed during WAIT/OUT/CLEAR; they are not issued before CLEAR completes.
- Reset mid-operation: FIFO contents are lost and the state returns to CLEAR. A late `mac_done` is ignored.

## Structure
- **Package `fp8_mac_pkg`:** `FP8_W`=8, the state enum `seq_state_t`, and the `fifo_entry_t` struct {last, a, b}.
- **Sub-module `fp8_pair_fifo`:** synchronous FIFO of `fifo_entry_t`, `DEPTH` entries, with full/empty flags.
- **Top level:** the FSM, timeout counter, pair counter and result register.

## Test plan
All scenarios use a behavioural PE model with done 3 cycles after start, and E4M3 encoding (1.0=0x38, 2.0=0x40).
- **Reset:** `rst` high for 3 cycles → all outputs 0 except `mac_clr`=1. `mac_clr` is still 1 in the first cycle after release, then 0. `in_ready`=1.
- **Single pair:** push a=0x38, b=0x40, last=1 → one `mac_start` with `mac_a`=0x38, `mac_b`=0x40. Then `out_valid` with `out_data`=model acc 0x40, `out_count`=1, `out_err`=0. After `out_ready`, one `mac_clr` pulse.
- **Back-to-back vector:** 6 pairs, last on the 6th, pushed back-to-back with `DEPTH`=4 → `in_ready` drops while the FIFO is full. Exactly 6 `mac_start` pulses, each the cycle after the previous done. `out_count`=6.
- **Result backpressure:** `out_ready` low for 10 cycles while a second vector is pushed → `out_*` stable, no `mac_start`, `in_ready`=0 after 4 pushes. The second vector issues only after CLEAR.
- **Timeout:** model never asserts done; 3-pair vector with `TIMEOUT`=16 → `out_err`=1 after 16 WAIT cycles. The remaining 2 entries are discarded with no further `mac_start`. `out_count`=0.
- **Reset mid-WAIT:** assert `rst` mid-WAIT; the model's done arrives 1 cycle after release → done ignored, FIFO empty, no `out_valid`.
